fft_frame_scheduler: RTL and testbench

Sequences the spectral-analysis path between the last FIR decimator stage and the note writer. It gates decimated samples into the Hanning window / FFT as whole frames, and waits for the FFT to drain and the peak finder to report. It then commits each frame's peak bin and flags a note only after the bin has held steady over several frames. It also counts dropped samples and frames, and recovers from a missing peak with a timeout.

---
 rtl/fft_frame_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_fft_frame_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_scheduler.sv
// Frame scheduler between the decimator and the note writer: gates whole frames into
// the window/FFT, waits for the peak result, and confirms a note once the bin is stable.
module fft_frame_scheduler #(
    parameter int unsigned FRAME_LEN    = 1024,
    parameter int unsigned PEAK_TIMEOUT = 4096,
    parameter int unsigned HOLD_FRAMES  = 3
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        record_in,
    input  logic        sample_valid_in,
    output logic        win_valid_out,
    output logic        frame_start_out,
    input  logic        fft_ready_in,
    input  logic        fft_valid_in,
    input  logic        fft_last_in,
    input  logic        peak_valid_in,
    input  logic [11:0] peak_in,
    output logic        commit_out,
    output logic [11:0] peak_out,
    output logic        note_strobe_out,
    output logic        busy_out,
    output logic        timeout_out,
    output logic [15:0] frame_count_out,
    output logic [15:0] dropped_count_out
);

    localparam int unsigned FillW = $clog2(FRAME_LEN + 1);
    localparam int unsigned WaitW = $clog2(PEAK_TIMEOUT);
    localparam int unsigned RunW  = $clog2(HOLD_FRAMES + 1);

    localparam logic [FillW-1:0] FillLast = FillW'(FRAME_LEN - 1);
    localparam logic [WaitW-1:0] WaitLast = WaitW'(PEAK_TIMEOUT - 1);
    localparam logic [RunW-1:0]  RunHold  = RunW'(HOLD_FRAMES);
    localparam logic [RunW-1:0]  RunOne   = RunW'(1);

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StFill,
        StDrain,
        StWaitPeak,
        StCommit
    } state_e;

    state_e           state_q, state_d;
    logic [FillW-1:0] fill_cnt_q, fill_cnt_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic [RunW-1:0]  run_cnt_q, run_cnt_d;
    logic [11:0]      prev_bin_q, prev_bin_d;
    logic [11:0]      peak_q, peak_d;
    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic [15:0]      drop_cnt_q, drop_cnt_d;
    logic             commit_q, commit_d;
    logic             note_q, note_d;
    logic             timeout_q, timeout_d;
    logic             frame_start_q, frame_start_d;
    logic             same_bin;
    logic             drop;

    always_comb begin
        state_d       = state_q;
        fill_cnt_d    = fill_cnt_q;
        wait_cnt_d    = wait_cnt_q;
        run_cnt_d     = run_cnt_q;
        prev_bin_d    = prev_bin_q;
        peak_d        = peak_q;
        frame_cnt_d   = frame_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        commit_d      = 1'b0;
        note_d        = 1'b0;
        timeout_d     = 1'b0;
        frame_start_d = 1'b0;
        same_bin      = (peak_in == prev_bin_q);

        // Samples outside FILL are lost; IDLE is not recording so those are not drops.
        drop = sample_valid_in &&
               (state_q inside {StArm, StDrain, StWaitPeak, StCommit});
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        case (state_q)
            StIdle: begin
                if (record_in) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                if (fft_ready_in) begin
                    state_d       = StFill;
                    fill_cnt_d    = '0;
                    frame_start_d = 1'b1;
                end
            end
            StFill: begin
                if (sample_valid_in) begin
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_q == FillLast) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (fft_valid_in && fft_last_in) begin
                    state_d    = StWaitPeak;
                    wait_cnt_d = '0;
                end
            end
            StWaitPeak: begin
                // A peak arriving on the expiry cycle takes priority over the timeout.
                if (peak_valid_in) begin
                    state_d     = StCommit;
                    commit_d    = 1'b1;
                    peak_d      = peak_in;
                    prev_bin_d  = peak_in;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    if (!same_bin) begin
                        run_cnt_d = RunOne;
                    end else if (run_cnt_q != RunHold) begin
                        run_cnt_d = run_cnt_q + 1'b1;
                    end
                    note_d = (run_cnt_d == RunHold) && (!same_bin || (run_cnt_q != RunHold));
                end else if (wait_cnt_q == WaitLast) begin
                    timeout_d = 1'b1;
                    run_cnt_d = '0;
                    state_d   = record_in ? StArm : StIdle;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            StCommit: begin
                state_d = record_in ? StArm : StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q       <= StIdle;
            fill_cnt_q    <= '0;
            wait_cnt_q    <= '0;
            run_cnt_q     <= '0;
            prev_bin_q    <= 12'hFFF;
            peak_q        <= '0;
            frame_cnt_q   <= '0;
            drop_cnt_q    <= '0;
            commit_q      <= 1'b0;
            note_q        <= 1'b0;
            timeout_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_cnt_q    <= fill_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            run_cnt_q     <= run_cnt_d;
            prev_bin_q    <= prev_bin_d;
            peak_q        <= peak_d;
            frame_cnt_q   <= frame_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            commit_q      <= commit_d;
            note_q        <= note_d;
            timeout_q     <= timeout_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign win_valid_out     = (state_q == StFill) && sample_valid_in;
    assign frame_start_out   = frame_start_q;
    assign commit_out        = commit_q;
    assign peak_out          = peak_q;
    assign note_strobe_out   = note_q;
    assign busy_out          = (state_q != StIdle);
    assign timeout_out       = timeout_q;
    assign frame_count_out   = frame_cnt_q;
    assign dropped_count_out = drop_cnt_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Bench for fft_frame_scheduler: directed frames plus random traffic, every cycle compared
// against a phase-level reference model.
module tb_fft_frame_scheduler;

    localparam int FL = 8;
    localparam int PT = 16;
    localparam int HF = 3;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        record_in, sample_valid_in, fft_ready_in, fft_valid_in, fft_last_in;
    logic        peak_valid_in;
    logic [11:0] peak_in;
    logic        win_valid_out, frame_start_out, commit_out, note_strobe_out;
    logic        busy_out, timeout_out;
    logic [11:0] peak_out;
    logic [15:0] frame_count_out, dropped_count_out;

    always #5 clk_in = ~clk_in;

    fft_frame_scheduler #(
        .FRAME_LEN   (FL),
        .PEAK_TIMEOUT(PT),
        .HOLD_FRAMES (HF)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .record_in        (record_in),
        .sample_valid_in  (sample_valid_in),
        .win_valid_out    (win_valid_out),
        .frame_start_out  (frame_start_out),
        .fft_ready_in     (fft_ready_in),
        .fft_valid_in     (fft_valid_in),
        .fft_last_in      (fft_last_in),
        .peak_valid_in    (peak_valid_in),
        .peak_in          (peak_in),
        .commit_out       (commit_out),
        .peak_out         (peak_out),
        .note_strobe_out  (note_strobe_out),
        .busy_out         (busy_out),
        .timeout_out      (timeout_out),
        .frame_count_out  (frame_count_out),
        .dropped_count_out(dropped_count_out)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: phase of the frame lifecycle plus plain counters.
    localparam int P_IDLE = 0, P_ARM = 1, P_FILL = 2, P_DRAIN = 3, P_WAIT = 4, P_COMMIT = 5;
    int          m_phase, m_fill, m_waited, m_streak, m_frames, m_drops;
    logic [11:0] m_prev, m_peak;
    bit          m_commit, m_note, m_tout, m_fstart;
    bit          started = 0;

    function automatic void model_reset();
        m_phase = P_IDLE; m_fill = 0; m_waited = 0; m_streak = 0;
        m_frames = 0; m_drops = 0; m_prev = 12'hFFF; m_peak = 12'h000;
        m_commit = 0; m_note = 0; m_tout = 0; m_fstart = 0;
    endfunction

    function automatic void model_step();
        m_commit = 0; m_note = 0; m_tout = 0; m_fstart = 0;
        if (sample_valid_in && m_phase != P_IDLE && m_phase != P_FILL && m_drops < 65535)
            m_drops++;
        case (m_phase)
            P_IDLE:  if (record_in) m_phase = P_ARM;
            P_ARM:   if (fft_ready_in) begin m_phase = P_FILL; m_fill = 0; m_fstart = 1; end
            P_FILL:  if (sample_valid_in) begin
                         m_fill++;
                         if (m_fill == FL) m_phase = P_DRAIN;
                     end
            P_DRAIN: if (fft_valid_in && fft_last_in) begin m_phase = P_WAIT; m_waited = 0; end
            P_WAIT: begin
                if (peak_valid_in) begin
                    m_streak = (peak_in == m_prev) ? m_streak + 1 : 1;
                    m_note   = (m_streak == HF);
                    m_prev   = peak_in;
                    m_peak   = peak_in;
                    m_frames = (m_frames + 1) % 65536;
                    m_commit = 1;
                    m_phase  = P_COMMIT;
                end else begin
                    m_waited++;
                    if (m_waited == PT) begin
                        m_tout   = 1;
                        m_streak = 0;
                        m_phase  = record_in ? P_ARM : P_IDLE;
                    end
                end
            end
            default: m_phase = record_in ? P_ARM : P_IDLE;
        endcase
    endfunction

    always @(negedge rst_in) model_reset();
    always @(posedge clk_in) if (rst_in === 1'b1) model_step();

    int n_commit = 0, n_note = 0, last_note_at = 0, n_win = 0, n_fs = 0, n_tout = 0;
    int fs_with_sample = 0;

    always @(negedge clk_in) begin
        if (started) begin
            check("win_valid",   32'(win_valid_out),     32'(m_phase == P_FILL && sample_valid_in));
            check("frame_start", 32'(frame_start_out),   32'(m_fstart));
            check("commit",      32'(commit_out),        32'(m_commit));
            check("peak_out",    32'(peak_out),          32'(m_peak));
            check("note",        32'(note_strobe_out),   32'(m_note));
            check("busy",        32'(busy_out),          32'(m_phase != P_IDLE));
            check("timeout",     32'(timeout_out),       32'(m_tout));
            check("frame_count", 32'(frame_count_out),   32'(m_frames));
            check("dropped",     32'(dropped_count_out), 32'(m_drops));
            if (commit_out) n_commit++;
            if (note_strobe_out) begin n_note++; last_note_at = n_commit; end
            if (win_valid_out) n_win++;
            if (frame_start_out) n_fs++;
            if (frame_start_out && win_valid_out) fs_with_sample++;
            if (timeout_out) n_tout++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_phase(input int ph, input int bound, input string nm);
        int n;
        n = 0;
        while (m_phase != ph && n < bound) begin tick(); n++; end
        if (m_phase != ph) begin
            checks++;
            $display("FAIL %s: phase %0d, required %0d within %0d cycles", nm, m_phase, ph, bound);
        end
    endtask

    int tout_lat = 0;

    task automatic run_frame(input logic [11:0] bin, input bit do_peak, input int gap,
                             input int drain_s, input int wait_s, input bit wait_samp,
                             input bit stop_mid);
        int k;
        int n;
        record_in = 1; fft_ready_in = 1; sample_valid_in = 0;
        wait_phase(P_FILL, 10, "reach_fill");
        k = 0;
        while (m_phase == P_FILL && k < 400) begin
            sample_valid_in = (k % gap == 0);
            if (stop_mid && k == gap * 3) record_in = 0;
            tick();
            k++;
        end
        sample_valid_in = 0;
        repeat (drain_s) begin sample_valid_in = 1; tick(); end
        sample_valid_in = 0;
        fft_valid_in = 1; fft_last_in = 1;
        tick();
        fft_valid_in = 0; fft_last_in = 0;
        repeat (wait_s) begin sample_valid_in = wait_samp; tick(); end
        sample_valid_in = 0;
        if (do_peak) begin
            peak_valid_in = 1; peak_in = bin;
            tick();
            peak_valid_in = 0;
            tick();
        end else begin
            n = 0;
            do begin @(negedge clk_in); n++; end while (!timeout_out && n < 40);
            tout_lat = n;
            tick();
        end
    endtask

    initial begin
        int c0, n0, t0;
        logic [11:0] stab [6];
        stab[0] = 12'h010; stab[1] = 12'h010; stab[2] = 12'h011;
        stab[3] = 12'h011; stab[4] = 12'h011; stab[5] = 12'h011;

        rst_in = 0; record_in = 0; sample_valid_in = 0; fft_ready_in = 0;
        fft_valid_in = 0; fft_last_in = 0; peak_valid_in = 0; peak_in = 12'h000;
        model_reset();
        started = 1;
        #12;
        check("rst_busy", 32'(busy_out), 32'd0);
        check("rst_peak", 32'(peak_out), 32'd0);
        check("rst_frames", 32'(frame_count_out), 32'd0);
        check("rst_dropped", 32'(dropped_count_out), 32'd0);
        @(posedge clk_in); #3; rst_in = 1;
        tick();

        // Basic frame: sample every 4 cycles, first one lands on the frame_start cycle.
        run_frame(12'h02A, 1, 4, 0, 0, 0, 0);
        check("basic_win_pulses", 32'(n_win), 32'd8);
        check("basic_frame_starts", 32'(n_fs), 32'd1);
        check("basic_fs_with_sample", 32'(fs_with_sample), 32'd1);
        check("basic_peak", 32'(peak_out), 32'h02A);
        check("basic_frames", 32'(frame_count_out), 32'd1);
        check("basic_commits", 32'(n_commit), 32'd1);

        // Stability: only the 5th commit confirms a note.
        c0 = n_commit; n0 = n_note;
        for (int i = 0; i < 6; i++) run_frame(stab[i], 1, 1, 0, 2, 0, 0);
        check("stab_notes", 32'(n_note - n0), 32'd1);
        check("stab_note_at", 32'(last_note_at - c0), 32'd5);

        // Timeout, then three equal-bin frames must rebuild the run from 1.
        c0 = n_commit;
        run_frame(12'h000, 0, 1, 0, 0, 0, 0);
        check("timeout_latency", 32'(tout_lat), 32'd17);
        check("timeout_pulses", 32'(n_tout), 32'd1);
        check("timeout_no_commit", 32'(n_commit - c0), 32'd0);
        check("timeout_to_arm", 32'(busy_out), 32'd1);
        c0 = n_commit; n0 = n_note;
        for (int i = 0; i < 3; i++) run_frame(12'h011, 1, 2, 0, 1, 0, 0);
        check("rerun_notes", 32'(n_note - n0), 32'd1);
        check("rerun_note_at", 32'(last_note_at - c0), 32'd3);

        // Drops: 5 samples in DRAIN and 3 in WAIT_PEAK, none before.
        check("drops_before", 32'(dropped_count_out), 32'd0);
        run_frame(12'h033, 1, 1, 5, 3, 1, 0);
        check("drops_after", 32'(dropped_count_out), 32'd8);

        // Race: peak arrives on the 16th WAIT_PEAK cycle.
        c0 = n_commit; t0 = n_tout;
        run_frame(12'h033, 1, 1, 0, 15, 0, 0);
        check("race_commit", 32'(n_commit - c0), 32'd1);
        check("race_no_timeout", 32'(n_tout - t0), 32'd0);

        // Stop mid-FILL: frame still completes and commits, then idle.
        c0 = n_commit;
        run_frame(12'h055, 1, 2, 0, 0, 0, 1);
        @(negedge clk_in);
        check("stop_commit", 32'(n_commit - c0), 32'd1);
        check("stop_idle", 32'(busy_out), 32'd0);
        check("stop_frames", 32'(frame_count_out), 32'd13);
        check("stop_peak", 32'(peak_out), 32'h055);
        tick();

        // Drop counter saturation while parked in DRAIN.
        record_in = 1; fft_ready_in = 1;
        wait_phase(P_FILL, 10, "sat_fill");
        sample_valid_in = 1;
        repeat (65540) tick();
        check("drops_saturate", 32'(dropped_count_out), 32'hFFFF);
        sample_valid_in = 0;
        fft_valid_in = 1; fft_last_in = 1; tick();
        fft_valid_in = 0; fft_last_in = 0;
        peak_valid_in = 1; peak_in = 12'h077; tick();
        peak_valid_in = 0; tick();

        // Asynchronous reset in the middle of FILL.
        record_in = 1; fft_ready_in = 1;
        wait_phase(P_FILL, 10, "rst_fill");
        sample_valid_in = 1; tick(); tick();
        #2; rst_in = 0; #1;
        check("arst_busy", 32'(busy_out), 32'd0);
        check("arst_win", 32'(win_valid_out), 32'd0);
        check("arst_peak", 32'(peak_out), 32'd0);
        check("arst_frames", 32'(frame_count_out), 32'd0);
        check("arst_dropped", 32'(dropped_count_out), 32'd0);
        check("arst_pulses", 32'({frame_start_out, commit_out, note_strobe_out, timeout_out}),
              32'd0);
        @(posedge clk_in); #3; rst_in = 1; #1;
        check("arst_release_idle", 32'(busy_out), 32'd0);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            record_in       = ($urandom % 16) != 0;
            sample_valid_in = ($urandom % 3) == 0;
            fft_ready_in    = ($urandom % 4) != 0;
            fft_valid_in    = ($urandom % 4) == 0;
            fft_last_in     = ($urandom % 6) == 0;
            peak_valid_in   = ($urandom % 10) == 0;
            peak_in         = 12'h010 + 12'($urandom_range(0, 2));
            tick();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
